// File: rtl/expr_pipe_eval.sv
// ============================================================================
// Module   : expr_pipe_eval
// Purpose  : Elastic valid/ready pipeline evaluating one sized expression per
//            transaction, with optional rolling signature (EXPR_PIPE_SIG_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module expr_pipe_eval #(
   parameter int W      = 6,
   parameter int STAGES = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [2:0]    op,
   input  logic          a_sgn,
   input  logic          b_sgn,
   input  logic [W-1:0]  a,
   input  logic [W-1:0]  b,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  y,
   output logic          flag,
   output logic [31:0]   sig,
   output logic [15:0]   count
);

   localparam logic [31:0] c_W32 = W;

   logic               w_fill;
   logic               w_b_big;
   logic               w_lt;
   logic signed [W:0]  w_ext;
   logic [W-1:0]       w_shr;
   logic [W-1:0]       w_y;

   logic [STAGES-1:0]  r_v;
   logic [W:0]         r_pay   [STAGES];
   logic [STAGES-1:0]  w_ld;
   logic [STAGES-1:0]  w_src_v;
   logic [W:0]         w_src_p [STAGES];

   // Shift amount is always treated as unsigned, whatever b_sgn says.
   assign w_fill  = a_sgn & a[W-1];
   assign w_b_big = (32'(b) >= c_W32);
   assign w_ext   = {w_fill, a};
   assign w_shr   = W'(w_ext >>> b);
   assign w_lt    = (a_sgn && b_sgn) ? ($signed(a) < $signed(b)) : (a < b);

   always_comb begin
      w_y = '0;
      case (op)
         3'd0: w_y = a + b;
         3'd1: w_y = a - b;
         3'd2: w_y = ~(a ^ b);
         3'd3: w_y = w_b_big ? '0 : (a << b);
         3'd4: w_y = w_b_big ? {W{w_fill}} : w_shr;
         3'd5: w_y = {{(W-1){1'b0}}, (a == b)};
         3'd6: w_y = a * b;
         3'd7: w_y = {{(W-1){1'b0}}, w_lt};
         default: w_y = '0;
      endcase
   end

   always_comb begin
      w_src_v[0] = in_valid;
      w_src_p[0] = {^w_y, w_y};
      for (int i = 1; i < STAGES; i++) begin
         w_src_v[i] = r_v[i-1];
         w_src_p[i] = r_pay[i-1];
      end
   end

   // A stage may load when any slot from it to the tail is empty, or the tail drains.
   always_comb begin
      for (int i = 0; i < STAGES; i++) begin
         w_ld[i] = out_ready;
         for (int j = i; j < STAGES; j++) begin
            if (!r_v[j]) w_ld[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_v <= '0;
         for (int i = 0; i < STAGES; i++) r_pay[i] <= '0;
      end else begin
         for (int i = 0; i < STAGES; i++) begin
            if (w_ld[i]) begin
               r_v[i] <= w_src_v[i];
               if (w_src_v[i]) r_pay[i] <= w_src_p[i];
            end
         end
      end
   end

   assign in_ready  = w_ld[0];
   assign out_valid = r_v[STAGES-1];
   assign y         = r_pay[STAGES-1][W-1:0];
   assign flag      = r_pay[STAGES-1][W];

`ifdef EXPR_PIPE_SIG_EN
   logic [31:0] r_sig;
   logic [15:0] r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sig   <= '0;
         r_count <= '0;
      end else if (out_valid && out_ready) begin
         r_sig <= {r_sig[30:0], r_sig[31]} ^ {{(31-W){1'b0}}, flag, y};
         if (r_count != 16'hFFFF) r_count <= r_count + 16'd1;
      end
   end

   assign sig   = r_sig;
   assign count = r_count;
`else
   assign sig   = '0;
   assign count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_expr_pipe_eval.sv
// ============================================================================
// Module   : tb_expr_pipe_eval
// Purpose  : Scoreboard bench for expr_pipe_eval (W=6, STAGES=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_expr_pipe_eval;

   localparam int W      = 6;
   localparam int STAGES = 2;
`ifdef EXPR_PIPE_SIG_EN
   localparam bit SIG_EN = 1'b1;
`else
   localparam bit SIG_EN = 1'b0;
`endif

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [2:0]    op;
   logic          a_sgn;
   logic          b_sgn;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  y;
   logic          flag;
   logic [31:0]   sig;
   logic [15:0]   count;

   expr_pipe_eval #(.W(W), .STAGES(STAGES)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a_sgn(a_sgn), .b_sgn(b_sgn), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready), .y(y), .flag(flag),
      .sig(sig), .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] y;
      logic         flag;
   } exp_t;

   exp_t         q[$];
   int           n_cmp = 0;
   int           n_bad = 0;
   logic [31:0]  m_sig = '0;
   logic [15:0]  m_cnt = '0;
   logic         prev_stall = 1'b0;
   logic [W-1:0] prev_y = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: plain integer arithmetic on the operand values, then mod 2^W.
   function automatic logic [W-1:0] ref_eval(input logic [2:0] f_op, input logic f_as,
                                              input logic f_bs, input logic [W-1:0] f_a,
                                              input logic [W-1:0] f_b);
      int ua, ub, sa, sb, r;
      ua = int'(f_a);
      ub = int'(f_b);
      sa = (f_as && f_a[W-1]) ? ua - (2**W) : ua;
      sb = (f_bs && f_b[W-1]) ? ub - (2**W) : ub;
      case (f_op)
         3'd0: r = ua + ub;
         3'd1: r = ua - ub;
         3'd2: r = ~(ua ^ ub);
         3'd3: r = (ub >= W) ? 0 : (ua << ub);
         3'd4: r = (ub >= W) ? ((sa < 0) ? -1 : 0) : (sa >>> ub);
         3'd5: r = (ua == ub) ? 1 : 0;
         3'd6: r = ua * ub;
         default: r = (f_as && f_bs) ? ((sa < sb) ? 1 : 0) : ((ua < ub) ? 1 : 0);
      endcase
      return r[W-1:0];
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (!rst && in_valid && in_ready) begin
         e.y    = ref_eval(op, a_sgn, b_sgn, a, b);
         e.flag = ^e.y;
         q.push_back(e);
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         chk("sig", sig, SIG_EN ? m_sig : 32'h0);
         chk("count", 32'(count), SIG_EN ? 32'(m_cnt) : 32'h0);
         if (out_valid && prev_stall) chk("y_hold", 32'(y), 32'(prev_y));
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("unexpected_output", 32'h1, 32'h0);
            end else begin
               e = q.pop_front();
               chk("y", 32'(y), 32'(e.y));
               chk("flag", 32'(flag), 32'(e.flag));
               m_sig = {m_sig[30:0], m_sig[31]} ^ 32'({e.flag, e.y});
               if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_y     = y;
      end
   end

   task automatic send(input logic [2:0] t_op, input logic t_as, input logic t_bs,
                       input logic [W-1:0] t_a, input logic [W-1:0] t_b);
      int t;
      in_valid = 1'b1; op = t_op; a_sgn = t_as; b_sgn = t_bs; a = t_a; b = t_b;
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 20) begin
         t++;
         @(negedge clk);
      end
      if (!in_ready) chk("accept_timeout", 32'h0, 32'h1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      for (int t = 0; t < 100; t++) begin
         if (q.size() == 0 && !out_valid) break;
         @(negedge clk);
      end
      chk("drain_timeout", 32'(q.size()), 32'h0);
   endtask

   task automatic rand_fields();
      op    = 3'($urandom);
      a_sgn = 1'($urandom);
      b_sgn = 1'($urandom);
      a     = W'($urandom);
      b     = ($urandom % 2 == 0) ? W'($urandom % 8) : W'($urandom);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      int k;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      op = '0; a_sgn = 1'b0; b_sgn = 1'b0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_y", 32'(y), 32'h0);
      chk("rst_flag", 32'(flag), 32'h0);
      chk("rst_sig", sig, 32'h0);
      chk("rst_count", 32'(count), 32'h0);
      rst = 1'b0;
      #1;
      chk("in_ready_after_rst", 32'(in_ready), 32'h1);

      // Add wrap with latency check, then the signature sequence 0, 0x08, 0x38.
      send(3'd0, 1'b0, 1'b0, 6'd63, 6'd1);
      @(negedge clk);
      chk("lat_early", 32'(out_valid), 32'h0);
      @(negedge clk);
      chk("lat_valid", 32'(out_valid), 32'h1);
      chk("add_wrap_y", 32'(y), 32'h0);
      @(posedge clk); #1;
      send(3'd4, 1'b0, 1'b0, 6'b100000, 6'd2);
      send(3'd4, 1'b1, 1'b0, 6'b100000, 6'd2);
      wait_drain();
      chk("sig_seq", sig, SIG_EN ? 32'hE8 : 32'h0);
      chk("count_seq", 32'(count), SIG_EN ? 32'd3 : 32'h0);
      @(posedge clk); #1;

      send(3'd7, 1'b1, 1'b1, 6'h3F, 6'd1);
      send(3'd7, 1'b1, 1'b0, 6'h3F, 6'd1);
      send(3'd4, 1'b1, 1'b0, 6'b100000, 6'd9);
      send(3'd3, 1'b0, 1'b0, 6'h15, 6'd6);
      wait_drain();
      @(posedge clk); #1;

      // Backpressure: four offered, two absorbed while stalled.
      out_ready = 1'b0;
      acc = 0;
      rand_fields();
      in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (in_ready) acc++;
         @(posedge clk); #1;
         if (acc > 0 && acc <= 4) rand_fields();
      end
      chk("bp_accepts", 32'(acc), 32'd2);
      chk("bp_in_ready", 32'(in_ready), 32'h0);
      out_ready = 1'b1;
      #1;
      chk("full_drain_in_ready", 32'(in_ready), 32'h1);
      k = acc;
      for (int t = 0; t < 20 && k < 4; t++) begin
         @(negedge clk);
         if (in_ready) k++;
         @(posedge clk); #1;
         rand_fields();
      end
      in_valid = 1'b0;
      chk("bp_total", 32'(k), 32'd4);
      wait_drain();
      @(posedge clk); #1;

      // Reset with two in flight.
      out_ready = 1'b0;
      send(3'd2, 1'b0, 1'b0, 6'h12, 6'h05);
      send(3'd6, 1'b0, 1'b0, 6'h07, 6'h09);
      #2;
      rst = 1'b1;
      q.delete();
      m_sig = '0;
      m_cnt = '0;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'h0);
      chk("midrst_sig", sig, 32'h0);
      chk("midrst_count", 32'(count), 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      out_ready = 1'b1;
      send(3'd1, 1'b0, 1'b0, 6'd3, 6'd5);
      @(negedge clk);
      chk("post_rst_lat_early", 32'(out_valid), 32'h0);
      @(negedge clk);
      chk("post_rst_lat_valid", 32'(out_valid), 32'h1);
      @(posedge clk); #1;

      // Random traffic with random backpressure.
      for (int n = 0; n < 600; n++) begin
         in_valid  = ($urandom % 4) != 0;
         out_ready = ($urandom % 4) != 0;
         rand_fields();
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      wait_drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/expr_pipe_eval.md
# expr_pipe_eval

Parametrised, pipelined successor to the combinational expression-regression blocks. Evaluates one Verilog-sized expression per transaction (opcode, two operands with per-operand signedness) through an elastic valid/ready pipeline of configurable depth. Folds every accepted result into a rolling signature so long random streams can be compared against a golden model. Sits in the expression-regression bench between the stimulus generator and the checker.

## Interface
- W, 6: operand and result width, legal 2..16
- STAGES, 2: pipeline register depth, legal 1..4
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input transaction present
- in_ready  out  1  pipeline accepts input this cycle
- op  in  3  opcode (see Operation)
- a_sgn  in  1  operand a is signed
- b_sgn  in  1  operand b is signed
- a  in  W  operand a
- b  in  W  operand b
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- y  out  W  result, truncated to W bits
- flag  out  1  XOR-reduction of y
- sig  out  32  rolling result signature
- count  out  16  accepted-result count, saturating

## Operation
- Opcodes, result taken modulo 2^W:
  - 0: a+b
  - 1: a-b
  - 2: a ^~ b
  - 3: a << b; b is always unsigned; amount >= W gives 0
  - 4: a >>> b; sign-fill only if a_sgn, else zero-fill; amount >= W gives all-fill
  - 5: a == b, zero-extended to W
  - 6: a*b, low W bits
  - 7: a < b, zero-extended. Signed compare only when a_sgn and b_sgn are both 1; any mixed or unsigned pair compares unsigned (Verilog context rule).
- Evaluation happens combinationally at the input; the result plus flag are carried through the pipeline registers.
- Elastic pipeline of STAGES slots, each holding a valid bit and payload. Stage i loads when it is empty or is itself draining this cycle. The last stage drains on out_valid && out_ready.
- in_ready is 1 when stage 0 is empty or draining. The out_ready→in_ready path is combinational. There is no in_valid→in_ready path.
- Transactions are never dropped or duplicated, and order is preserved.
- Signature: on each output handshake, sig <= rotl1(sig) ^ zero-extend({flag, y}), and count <= count+1, saturating at 0xFFFF.

## Timing
- Reset values: out_valid=0, y=0, flag=0, sig=0, count=0, all slot valids 0. in_ready=1 once rst deasserts.
- Latency: an input accepted at edge N appears on out_valid/y after edge N+STAGES-1, i.e. visible in cycle N+STAGES. This holds when there is no stall.
- Throughput: one transaction per cycle with out_ready held at 1.
- Full: with out_ready=0, exactly STAGES transactions are absorbed; then in_ready=0.
- Simultaneous input and output handshake while full: both complete in the same cycle, and occupancy is unchanged.
- y/flag hold stable while out_valid=1 and out_ready=0.
- Reset mid-stream: every in-flight transaction is discarded immediately (asynchronously), sig and count clear, and no partial output appears.

## Configuration
- EXPR_PIPE_SIG_EN defined: sig/count logic as described.
- EXPR_PIPE_SIG_EN undefined: signature and counter logic are removed; sig and count are tied to 0. The pipeline is otherwise identical.

## Test plan
All scenarios use W=6, STAGES=2, out_ready=1 unless stated.
- Add wrap: op=0, a=63, b=1 → y=0, flag=0, out_valid in the 2nd cycle after acceptance.
- Signedness rule: op=7, a=6'h3F, b=1, a_sgn=b_sgn=1 → y=1. Same inputs with b_sgn=0 → y=0.
- Arithmetic shift: op=4, a=6'b100000, b=2, a_sgn=1 → y=6'b111000. With a_sgn=0 → y=6'b001000. With b=9, a_sgn=1 → y=6'h3F.
- Backpressure: stream 4 transactions with out_ready=0 for 5 cycles → in_ready falls after 2 accepts. Release → 4 results arrive in order, none lost.
- Signature: results y=0, y=6'h08, y=6'h38 in sequence → sig=0x0, then 0x48, then 0xE8; count=3. Without EXPR_PIPE_SIG_EN, sig=0 and count=0 throughout.
- Reset mid-stream: assert rst with 2 in flight → out_valid=0, sig=0, count=0 at once. After release, the first new input emerges with the normal 2-cycle latency.
